mux_rx_deser: RTL
=================

// Module: mux_rx_deser
// PURPOSE
//  Receive end of the 4-lane byte-serial mux link. Each 32-bit word arrives as 4 consecutive valid
//  bytes, MSB first, on the lane in_data[in_chan]; all other lanes are zero. This block reassembles
//  words, tags each with its channel, checks link protocol and buffers words in an output FIFO
//  drained through a valid/ready handshake. The link has no backpressure, so overflow drops words.
// PARAMETERS
//  FIFO_DEPTH  4  output FIFO entries (power of 2, >=2)
//  CNT_W       8  width of the saturating drop counter
// PORTS
//  clk         in   1      clock; all logic is posedge
//  rst         in   1      reset, synchronous, active-high
//  in_valid    in   1      link byte valid
//  in_chan     in   2      link channel, selects the active lane
//  in_data0    in   8      lane 0 byte
//  in_data1    in   8      lane 1 byte
//  in_data2    in   8      lane 2 byte
//  in_data3    in   8      lane 3 byte
//  out_valid   out  1      FIFO head word is valid
//  out_ready   in   1      consumer accepts the head word
//  out_chan    out  2      channel of the head word
//  out_data    out  32     reassembled head word
//  proto_err   out  1      one-cycle pulse on a protocol error
//  err_code    out  2      cause, valid with proto_err: 1=GAP, 2=CHAN_SWITCH, 3=LANE; 0 otherwise
//  overflow    out  1      sticky; set on the first dropped word; cleared only by rst
//  drop_cnt    out  CNT_W  saturating count of words dropped because the FIFO was full
// BEHAVIOUR
//  - Reset: out_valid=0, out_chan=0, out_data=0, proto_err=0, err_code=0, overflow=0, drop_cnt=0.
//    Reset empties the FIFO, byte index=0, state=IDLE, and discards any partial word.
//  - FSM has two states, IDLE and COLLECT, plus a 2-bit byte index idx.
//    - IDLE & in_valid: capture the lane byte into bits[31:24], latch in_chan, set idx=1, go to COLLECT.
//    - COLLECT & in_valid & same chan: capture the byte into bits[31-8*idx -: 8], then idx++.
//    - On the 4th byte (idx==3): write the word and channel into the FIFO at that same edge,
//      set idx=0 and go to IDLE.
//  - Back-to-back words (in_valid held high) are accepted with no gap cycle.
//  - Latency: out_valid rises the cycle after the 4th byte edge, when the FIFO was empty.
//  - out_valid, out_chan and out_data are driven from the FIFO head. A pop occurs when out_valid & out_ready.
//    Head data stays stable while out_valid=1 and out_ready=0.
//  - Errors are registered and pulse on the cycle after the offending input; the partial word is discarded.
//    - GAP: state COLLECT and in_valid=0. Return to IDLE.
//    - CHAN_SWITCH: state COLLECT, in_valid=1 and in_chan differs from the latched channel.
//      The current byte becomes byte 0 of a new word on the new channel (idx=1).
//    - LANE: in_valid=1 and any non-selected lane is nonzero. The byte is still accepted.
//      If this coincides with CHAN_SWITCH, err_code reports CHAN_SWITCH.
//    - A nonzero lane while in_valid=0 is not checked.
//  - FIFO full on word completion:
//    - With a pop in the same cycle, the word is accepted; occupancy is unchanged.
//    - Without a pop, the word is dropped: overflow<=1, and drop_cnt increments and saturates
//      at all-ones. No proto_err is raised.
//  - Pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra pointer bit.
//    Full FIFO_DEPTH occupancy is usable.
// TESTING
//  1. in_chan=2, in_data2 = AA,BB,CC,DD over 4 valid cycles
//     -> out_valid next cycle, out_chan=2, out_data=AABBCCDD.
//  2. Three back-to-back words (ch0 11223344, ch3 55667788, ch1 99AABBCC) with out_ready=1
//     -> 3 words in order, no errors.
//  3. ch1 bytes 01,02 then in_valid=0 for one cycle, then 4 bytes 10..13
//     -> proto_err with err_code=1; only 10111213 is output.
//  4. ch0 bytes 01,02 then ch3 bytes 0A,0B,0C,0D
//     -> proto_err with err_code=2; only ch3 0A0B0C0D is output.
//  5. ch1 byte with in_data0=5 -> err_code=3; the word still completes correctly.
//  6. out_ready=0 and FIFO_DEPTH+2 words sent -> overflow=1, drop_cnt=2, first 4 words retained.
//     Repeat with a pop on the 5th word's edge -> 5th word is accepted.
//     Assert rst mid-word -> all outputs return to reset values.

Source files
------------

// File: rtl/mux_rx_deser.sv
// Receive side of the 4-lane byte-serial mux link: reassembles MSB-first words per channel,
// flags link protocol errors and buffers completed words in a small valid/ready FIFO.
module mux_rx_deser #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_chan,
  input  logic [7:0]       in_data0,
  input  logic [7:0]       in_data1,
  input  logic [7:0]       in_data2,
  input  logic [7:0]       in_data3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_chan,
  output logic [31:0]      out_data,
  output logic             proto_err,
  output logic [1:0]       err_code,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_GAP  = 2'd1;
  localparam logic [1:0] ERR_CHAN = 2'd2;
  localparam logic [1:0] ERR_LANE = 2'd3;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t      state_p0, state_n;
  logic [1:0]  idx_p0, idx_n;
  logic [1:0]  chan_p0, chan_n;
  logic [23:0] hi_p0, hi_n;
  logic        wr_en;
  logic        err_n;
  logic [1:0]  code_n;
  logic [7:0]  lane_byte;
  logic        lane_err;

  logic [33:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        push, pop, drop;

  // Lane select and stray-lane detection on the incoming link byte
  always_comb begin
    lane_byte = 8'h00;
    case (in_chan)
      2'd0:    lane_byte = in_data0;
      2'd1:    lane_byte = in_data1;
      2'd2:    lane_byte = in_data2;
      default: lane_byte = in_data3;
    endcase
    lane_err = in_valid && (((in_chan != 2'd0) && (in_data0 != 8'h00)) ||
                            ((in_chan != 2'd1) && (in_data1 != 8'h00)) ||
                            ((in_chan != 2'd2) && (in_data2 != 8'h00)) ||
                            ((in_chan != 2'd3) && (in_data3 != 8'h00)));
  end

  always_comb begin
    state_n = state_p0;
    idx_n   = idx_p0;
    chan_n  = chan_p0;
    hi_n    = hi_p0;
    wr_en   = 1'b0;
    err_n   = 1'b0;
    code_n  = ERR_NONE;
    case (state_p0)
      IDLE: begin
        if (in_valid) begin
          hi_n[23:16] = lane_byte;
          chan_n      = in_chan;
          idx_n       = 2'd1;
          state_n     = COLLECT;
        end
      end
      default: begin
        if (!in_valid) begin
          err_n   = 1'b1;
          code_n  = ERR_GAP;
          idx_n   = 2'd0;
          state_n = IDLE;
        end else if (in_chan != chan_p0) begin
          // The switching byte restarts a fresh word on the new channel
          err_n       = 1'b1;
          code_n      = ERR_CHAN;
          hi_n[23:16] = lane_byte;
          chan_n      = in_chan;
          idx_n       = 2'd1;
        end else begin
          case (idx_p0)
            2'd1: begin
              hi_n[15:8] = lane_byte;
              idx_n      = 2'd2;
            end
            2'd2: begin
              hi_n[7:0] = lane_byte;
              idx_n     = 2'd3;
            end
            2'd3: begin
              wr_en   = 1'b1;
              idx_n   = 2'd0;
              state_n = IDLE;
            end
            default: begin
              idx_n   = 2'd0;
              state_n = IDLE;
            end
          endcase
        end
      end
    endcase
    if (lane_err && (code_n == ERR_NONE)) begin
      err_n  = 1'b1;
      code_n = ERR_LANE;
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = out_valid && out_ready;
  assign push       = wr_en && (!fifo_full || pop);
  assign drop       = wr_en && fifo_full && !pop;

  assign out_valid = !fifo_empty;
  assign out_chan  = out_valid ? mem[rd_ptr[AW-1:0]][33:32] : 2'd0;
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]][31:0]  : 32'd0;

  // Stage p0: assembly state, error pulse and FIFO control
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= IDLE;
      idx_p0    <= 2'd0;
      chan_p0   <= 2'd0;
      proto_err <= 1'b0;
      err_code  <= ERR_NONE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state_p0  <= state_n;
      idx_p0    <= idx_n;
      chan_p0   <= chan_n;
      proto_err <= err_n;
      err_code  <= code_n;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    hi_p0 <= hi_n;
    if (push) mem[wr_ptr[AW-1:0]] <= {chan_p0, hi_p0, lane_byte};
  end

endmodule
